rob_arat: RTL

- Commit-side architectural rename table (ARAT), instantiated in the ROB/retire stage.
- Up to 4 instructions retire per cycle. For each retiring instruction with a non-zero destination, the block:
  - records the committed ARF→PRF mapping;
  - computes the PRF that is now dead;
  - queues that PRF for return to the free list.
- On an exception flush it drives a one-cycle restore pulse carrying all 32 committed mappings to the decode speculative rename table (its flush-input side).

---
 rtl/rob_arat_pkg.sv | 16 +
 rtl/rob_arat_if.sv | 40 ++++
 rtl/rob_arat_rel_fifo.sv | 65 ++++++
 rtl/rob_arat.sv | 106 ++++++++++
 4 files changed

// File: rtl/rob_arat_pkg.sv
// Shared widths, lane counts and state encoding for the commit-side rename table.
package rob_arat_pkg;

   localparam int unsigned ARF_CODE_WIDTH     = 5;
   localparam int unsigned PRF_CODE_WIDTH     = 7;
   localparam int unsigned ARF_NUM            = 32;
   localparam int unsigned CMT_LANES          = 4;
   localparam int unsigned REL_LANES          = 2;
   localparam int unsigned REL_FIFO_DEPTH_DEF = 16;

   typedef enum logic {
      ARAT_IDLE  = 1'b0,
      ARAT_FLUSH = 1'b1
   } arat_state_e;

endpackage

// File: rtl/rob_arat_if.sv
// Retire, restore and release bus of rob_arat; ARAT_PERF_CNT_EN adds the perf counters.
interface rob_arat_if;
   import rob_arat_pkg::*;

   logic                      i_arat_cmt_vld       [CMT_LANES];
   logic [ARF_CODE_WIDTH-1:0] i_arat_cmt_dst_code  [CMT_LANES];
   logic [PRF_CODE_WIDTH-1:0] i_arat_cmt_prf_code  [CMT_LANES];
   logic                      o_arat_cmt_rdy;
   logic                      i_arat_except_flush;
   logic                      o_arat_srat_flush;
   logic [PRF_CODE_WIDTH-1:0] o_arat_flush_prf_code [ARF_NUM];
   logic                      o_arat_rel_vld       [REL_LANES];
   logic [PRF_CODE_WIDTH-1:0] o_arat_rel_prf_code  [REL_LANES];
   logic                      i_arat_rel_rdy;
`ifdef ARAT_PERF_CNT_EN
   logic [31:0]               o_arat_perf_rel_cnt;
   logic [31:0]               o_arat_perf_stall_cnt;
`endif

   modport slave (
      input  i_arat_cmt_vld, i_arat_cmt_dst_code, i_arat_cmt_prf_code,
      input  i_arat_except_flush, i_arat_rel_rdy,
`ifdef ARAT_PERF_CNT_EN
      output o_arat_perf_rel_cnt, o_arat_perf_stall_cnt,
`endif
      output o_arat_cmt_rdy, o_arat_srat_flush, o_arat_flush_prf_code,
      output o_arat_rel_vld, o_arat_rel_prf_code
   );

   modport master (
      output i_arat_cmt_vld, i_arat_cmt_dst_code, i_arat_cmt_prf_code,
      output i_arat_except_flush, i_arat_rel_rdy,
`ifdef ARAT_PERF_CNT_EN
      input  o_arat_perf_rel_cnt, o_arat_perf_stall_cnt,
`endif
      input  o_arat_cmt_rdy, o_arat_srat_flush, o_arat_flush_prf_code,
      input  o_arat_rel_vld, o_arat_rel_prf_code
   );

endinterface

// File: rtl/rob_arat_rel_fifo.sv
// Release queue toward the free list: up to 4 compacted pushes and 2 pops per cycle.
module rob_arat_rel_fifo
   import rob_arat_pkg::*;
#(
   parameter int unsigned DEPTH = REL_FIFO_DEPTH_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push_vld_i  [CMT_LANES],
   input  logic [PRF_CODE_WIDTH-1:0]        push_code_i [CMT_LANES],
   input  logic                             pop_i,
   output logic                             pop_vld_o   [REL_LANES],
   output logic [PRF_CODE_WIDTH-1:0]        pop_code_o  [REL_LANES],
   output logic [$clog2(DEPTH):0]           count_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [PRF_CODE_WIDTH-1:0] mem_q   [DEPTH];
   logic [PTR_W-1:0]          wr_addr [CMT_LANES];
   logic [2:0]                push_n;
   logic [1:0]                pop_n;

   // Each valid lane takes the next free slot after the valid lanes before it.
   always_comb begin
      push_n = 3'd0;
      for (int k = 0; k < CMT_LANES; k++) begin
         wr_addr[k] = wr_ptr_q + PTR_W'(push_n);
         push_n     = push_n + 3'(push_vld_i[k]);
      end
      pop_n = 2'd0;
      if (pop_i) pop_n = (cnt_q >= CNT_W'(2)) ? 2'd2 : 2'(cnt_q[0]);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      cnt_d    = cnt_q + CNT_W'(push_n) - CNT_W'(pop_n);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < CMT_LANES; k++)
         if (push_vld_i[k]) mem_q[wr_addr[k]] <= push_code_i[k];
   end

   always_comb begin
      pop_vld_o[0]  = (cnt_q != '0);
      pop_vld_o[1]  = (cnt_q >= CNT_W'(2));
      pop_code_o[0] = mem_q[rd_ptr_q];
      pop_code_o[1] = mem_q[rd_ptr_q + PTR_W'(1)];
      count_o       = cnt_q;
   end

endmodule

// File: rtl/rob_arat.sv
// Commit-side architectural rename table: records retired mappings, releases dead PRFs,
// and restores decode on exception. ARAT_PERF_CNT_EN adds release/stall counters.
module rob_arat
   import rob_arat_pkg::*;
#(
   parameter int unsigned REL_FIFO_DEPTH = REL_FIFO_DEPTH_DEF
) (
   input logic       clk,
   input logic       rst_n,
   rob_arat_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(REL_FIFO_DEPTH) + 1;

   arat_state_e               state_q, state_d;
   logic [PRF_CODE_WIDTH-1:0] table_q  [ARF_NUM];
   logic [PRF_CODE_WIDTH-1:0] table_d  [ARF_NUM];
   logic                      acc      [CMT_LANES];
   logic [PRF_CODE_WIDTH-1:0] rel_code [CMT_LANES];
   logic                      rel_vld  [REL_LANES];
   logic [PRF_CODE_WIDTH-1:0] rel_prf  [REL_LANES];
   logic [CNT_W-1:0]          fifo_cnt;
   logic                      cmt_rdy;

   assign cmt_rdy = (state_q == ARAT_IDLE) &&
                    (fifo_cnt <= CNT_W'(REL_FIFO_DEPTH - CMT_LANES));

   // Dead PRF per lane bypasses older same-cycle writers; youngest writer wins the table.
   always_comb begin
      table_d = table_q;
      for (int k = 0; k < CMT_LANES; k++) begin
         acc[k]      = bus.i_arat_cmt_vld[k] && cmt_rdy && (bus.i_arat_cmt_dst_code[k] != '0);
         rel_code[k] = table_q[bus.i_arat_cmt_dst_code[k]];
         for (int j = 0; j < CMT_LANES; j++)
            if ((j < k) && acc[j] && (bus.i_arat_cmt_dst_code[j] == bus.i_arat_cmt_dst_code[k]))
               rel_code[k] = bus.i_arat_cmt_prf_code[j];
         if (acc[k]) table_d[bus.i_arat_cmt_dst_code[k]] = bus.i_arat_cmt_prf_code[k];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARAT_IDLE:  if (bus.i_arat_except_flush) state_d = ARAT_FLUSH;
         ARAT_FLUSH: state_d = bus.i_arat_except_flush ? ARAT_FLUSH : ARAT_IDLE;
         default:    state_d = ARAT_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARAT_IDLE;
         for (int i = 0; i < ARF_NUM; i++) table_q[i] <= PRF_CODE_WIDTH'(i);
      end else begin
         state_q <= state_d;
         table_q <= table_d;
      end
   end

   rob_arat_rel_fifo #(.DEPTH(REL_FIFO_DEPTH)) u_rel_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_vld_i  (acc),
      .push_code_i (rel_code),
      .pop_i       (bus.i_arat_rel_rdy),
      .pop_vld_o   (rel_vld),
      .pop_code_o  (rel_prf),
      .count_o     (fifo_cnt)
   );

   always_comb begin
      bus.o_arat_cmt_rdy        = cmt_rdy;
      bus.o_arat_srat_flush     = (state_q == ARAT_FLUSH);
      bus.o_arat_flush_prf_code = table_q;
      bus.o_arat_rel_vld        = rel_vld;
      bus.o_arat_rel_prf_code   = rel_prf;
   end

`ifdef ARAT_PERF_CNT_EN
   logic [31:0] perf_rel_q, perf_stall_q;
   logic [2:0]  push_n;
   logic        any_vld;

   always_comb begin
      push_n  = 3'd0;
      any_vld = 1'b0;
      for (int k = 0; k < CMT_LANES; k++) begin
         push_n  = push_n + 3'(acc[k]);
         any_vld = any_vld | bus.i_arat_cmt_vld[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_rel_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_rel_q   <= perf_rel_q + 32'(push_n);
         perf_stall_q <= perf_stall_q + 32'(any_vld && !cmt_rdy);
      end
   end

   assign bus.o_arat_perf_rel_cnt   = perf_rel_q;
   assign bus.o_arat_perf_stall_cnt = perf_stall_q;
`endif

endmodule
